// File: rtl/nrs_pkg.sv
// Shared definitions for the NRS bit-register controller.
// Holds the controller state encoding and the number of NRS bits per symbol.
// No logic lives here; it is imported by the controller and the bench.
package nrs_pkg;

  // Number of Gold-sequence bits carried by one NRS symbol. This is the
  // default depth of the NRS bit register.
  localparam int NRS_BITS_PER_SYM = 16;

  // Controller states. The encoding is fixed so that a state value seen in
  // a waveform or debug bus maps directly to a name.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } nrs_state_e;

endpackage

// File: rtl/nrs_reg_ctrl.sv
// Purpose : sequences the NRS bit register per symbol. It fills WIDTH_REG Gold bits
//           from the generator, then streams them to the channel estimator in address order.
// Latency : start->gen_req 1 cycle; best case start->done is 2*WIDTH_REG+2 cycles inclusive.
// Backpr. : generator gaps (gen_valid=0) hold the write address. Estimator stalls
//           (est_ready=0) hold rd_addr_est and est_valid.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   start        one-cycle request to run a fill/read sequence (accepted in IDLE only)
//   abort        one-cycle request to drop back to IDLE from any state
//   gen_req      asks the Gold generator for bits (high in FILL)
//   gen_valid    generator bit (c_n, wired straight to the register) is valid
//   wr_en        register write strobe, combinational with gen_valid in FILL
//   wr_addr      register write address
//   rd_addr_est  register read address; the register returns c_n_est to the estimator
//   est_valid    c_n_est is valid for the estimator (registered)
//   est_ready    estimator accepts the current bit
//   busy         controller is not IDLE
//   done         one-cycle pulse after the last bit has been accepted
module nrs_reg_ctrl
  import nrs_pkg::*;
#(
  parameter int WIDTH_REG = NRS_BITS_PER_SYM,
  parameter int LINES     = $clog2(WIDTH_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             gen_req,
  input  logic             gen_valid,
  output logic             wr_en,
  output logic [LINES-1:0] wr_addr,
  output logic [LINES-1:0] rd_addr_est,
  output logic             est_valid,
  input  logic             est_ready,
  output logic             busy,
  output logic             done
);

  // Counters stop at the last address instead of wrapping. This keeps the
  // final read address visible on rd_addr_est after the symbol completes.
  localparam logic [LINES-1:0] CNT_LAST = LINES'(WIDTH_REG - 1);
  localparam logic [LINES-1:0] CNT_ONE  = LINES'(1);
  localparam logic [LINES-1:0] CNT_ZERO = '0;

  nrs_state_e       state_q, state_d;
  logic [LINES-1:0] wr_cnt_q, wr_cnt_d;
  logic [LINES-1:0] rd_cnt_q, rd_cnt_d;
  logic             est_valid_q, est_valid_d;

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    gen_req  = 1'b0;
    wr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          wr_cnt_d = CNT_ZERO;
        end
      end

      FILL: begin
        gen_req = 1'b1;
        // The write strobe passes straight through from the generator's
        // valid signal, so a bit lands in the register in the same cycle.
        wr_en   = gen_valid;
        if (gen_valid) begin
          if (wr_cnt_q == CNT_LAST) begin
            state_d  = READ;
            rd_cnt_d = CNT_ZERO;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
          end
        end
      end

      READ: begin
        // est_valid is always high in READ, so est_ready alone completes
        // the handshake.
        if (est_ready) begin
          if (rd_cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
          end
        end
      end

      DONE: begin
        // A start arriving here is dropped; the next sequence needs a
        // fresh start in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything above, including a start in the same
    // cycle. Any write already strobed in this cycle still happens because
    // wr_en is not gated by abort.
    if (abort) begin
      state_d  = IDLE;
      wr_cnt_d = CNT_ZERO;
      rd_cnt_d = CNT_ZERO;
    end

    // est_valid is registered from the next state. It therefore rises one
    // cycle after the final write, once that bit is readable.
    est_valid_d = (state_d == READ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= CNT_ZERO;
      rd_cnt_q    <= CNT_ZERO;
      est_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      est_valid_q <= est_valid_d;
    end
  end

  assign wr_addr     = wr_cnt_q;
  assign rd_addr_est = rd_cnt_q;
  assign est_valid   = est_valid_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_nrs_reg_ctrl.sv
// Bench for nrs_reg_ctrl: a table of per-cycle vectors for the basic fill/read,
// plus short directed sequences for gaps, backpressure, abort, reset and ignored starts.
// A behavioural NRS bit register sits beside the controller, as it does in the design above.
module tb_nrs_reg_ctrl;
  import nrs_pkg::*;

  localparam int W = 16;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst, start, abort, gen_valid, est_ready, c_n;
  logic         gen_req, wr_en, est_valid, busy, done;
  logic [L-1:0] wr_addr, rd_addr_est;
  logic [W-1:0] nrs_reg;
  logic         c_n_est;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int wr_total = 0;
  int done_cyc = 0;

  nrs_reg_ctrl #(.WIDTH_REG(W), .LINES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gen_req(gen_req), .gen_valid(gen_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_addr_est(rd_addr_est), .est_valid(est_valid), .est_ready(est_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register model plus cycle/write/done counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en === 1'b1) begin
      nrs_reg[wr_addr] <= c_n;
      wr_total <= wr_total + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end
  assign c_n_est = nrs_reg[rd_addr_est];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    check("start_busy_before", 16'(busy), 16'd0);
    step();
    start = 1'b0;
    #1;
    check("start_gen_req_1cyc", 16'(gen_req), 16'd1);
  endtask

  // Writes n_wr bits of pat, one per valid cycle. With gaps, valid alternates 1,0,1,0...
  // Raises start for one cycle at iteration start_at (use -1 for none).
  task automatic fill(input logic [15:0] pat, input bit gaps, input int start_at, input int n_wr);
    int nwr = 0;
    int i   = 0;
    while (nwr < n_wr && i < 64) begin
      gen_valid = gaps ? (i % 2 == 0) : 1'b1;
      c_n       = gen_valid ? pat[nwr] : 1'b0;
      start     = (i == start_at);
      #1;
      check("fill_gen_req", 16'(gen_req), 16'd1);
      check("fill_busy", 16'(busy), 16'd1);
      check("fill_est_valid", 16'(est_valid), 16'd0);
      check("fill_wr_en", 16'(wr_en), 16'(gen_valid));
      check("fill_wr_addr", 16'(wr_addr), 16'(nwr));
      if (gen_valid) nwr++;
      step();
      i++;
    end
    gen_valid = 1'b0;
    start     = 1'b0;
    check("fill_write_count", 16'(nwr), 16'(n_wr));
  endtask

  // Reads n_bits bits and checks them against pat, stalling for stall_len
  // cycles at stall_addr. After a full read, checks the done pulse.
  task automatic read_seq(input logic [15:0] pat, input int stall_addr, input int stall_len,
                          input int n_bits, input bit start_in_done);
    for (int a = 0; a < n_bits; a++) begin
      if (a == stall_addr) begin
        for (int s = 0; s < stall_len; s++) begin
          est_ready = 1'b0;
          #1;
          check("stall_est_valid", 16'(est_valid), 16'd1);
          check("stall_rd_addr", 16'(rd_addr_est), 16'(a));
          step();
        end
      end
      est_ready = 1'b1;
      #1;
      check("read_est_valid", 16'(est_valid), 16'd1);
      check("read_rd_addr", 16'(rd_addr_est), 16'(a));
      check("read_c_n_est", 16'(c_n_est), 16'(pat[a]));
      step();
    end
    if (n_bits == W) begin
      start = start_in_done;
      #1;
      check("done_pulse", 16'(done), 16'd1);
      check("done_est_valid", 16'(est_valid), 16'd0);
      check("done_busy", 16'(busy), 16'd1);
      done_cyc = cyc;
      step();
      start = 1'b0;
      #1;
      check("after_done_pulse", 16'(done), 16'd0);
      check("after_done_busy", 16'(busy), 16'd0);
    end
  endtask

  typedef struct {
    logic         start, gen_valid, est_ready, c_n;
    logic         x_gen_req, x_wr_en;
    logic [L-1:0] x_wr_addr;
    logic         chk_wr_addr;
    logic         x_est_valid;
    logic [L-1:0] x_rd_addr;
    logic         x_busy, x_done, x_c_n_est, chk_c_n_est;
  } vec_t;

  vec_t        tbl[35];
  logic [15:0] pat1 = 16'hA5C3;

  initial begin
    int d0, w0, c0;

    // Basic sequence, cycle by cycle: k=0 is the start cycle, 1..16 FILL,
    // 17..32 READ, 33 DONE, 34 back in IDLE. gen_valid stays high throughout,
    // so the rows outside FILL also show that it is ignored there.
    for (int k = 0; k < 35; k++) begin
      tbl[k] = '{start: (k == 0), gen_valid: 1'b1, est_ready: 1'b1, c_n: 1'b0,
                 x_gen_req: 1'b0, x_wr_en: 1'b0, x_wr_addr: '0, chk_wr_addr: (k <= 16),
                 x_est_valid: 1'b0, x_rd_addr: '0, x_busy: 1'b0, x_done: 1'b0,
                 x_c_n_est: 1'b0, chk_c_n_est: 1'b0};
      if (k >= 1 && k <= 16) begin
        tbl[k].c_n       = pat1[k-1];
        tbl[k].x_gen_req = 1'b1;
        tbl[k].x_wr_en   = 1'b1;
        tbl[k].x_wr_addr = L'(k - 1);
        tbl[k].x_busy    = 1'b1;
      end
      if (k >= 17 && k <= 32) begin
        tbl[k].x_est_valid = 1'b1;
        tbl[k].x_rd_addr   = L'(k - 17);
        tbl[k].x_busy      = 1'b1;
        tbl[k].x_c_n_est   = pat1[k-17];
        tbl[k].chk_c_n_est = 1'b1;
      end
      if (k == 33) begin
        tbl[k].x_done    = 1'b1;
        tbl[k].x_busy    = 1'b1;
        tbl[k].x_rd_addr = 4'd15;
      end
      if (k == 34) tbl[k].x_rd_addr = 4'd15;
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; gen_valid = 1'b0; est_ready = 1'b0; c_n = 1'b0;
    @(negedge clk);
    step();
    #1;
    check("rst_gen_req", 16'(gen_req), 16'd0);
    check("rst_wr_en", 16'(wr_en), 16'd0);
    check("rst_wr_addr", 16'(wr_addr), 16'd0);
    check("rst_rd_addr", 16'(rd_addr_est), 16'd0);
    check("rst_est_valid", 16'(est_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    rst = 1'b0;
    step();

    // 1. Basic fill/read from the table.
    d0 = done_cnt; w0 = wr_total; c0 = cyc;
    for (int k = 0; k < 35; k++) begin
      start = tbl[k].start; gen_valid = tbl[k].gen_valid;
      est_ready = tbl[k].est_ready; c_n = tbl[k].c_n;
      #1;
      check($sformatf("t1[%0d] gen_req", k), 16'(gen_req), 16'(tbl[k].x_gen_req));
      check($sformatf("t1[%0d] wr_en", k), 16'(wr_en), 16'(tbl[k].x_wr_en));
      if (tbl[k].chk_wr_addr)
        check($sformatf("t1[%0d] wr_addr", k), 16'(wr_addr), 16'(tbl[k].x_wr_addr));
      check($sformatf("t1[%0d] est_valid", k), 16'(est_valid), 16'(tbl[k].x_est_valid));
      check($sformatf("t1[%0d] rd_addr", k), 16'(rd_addr_est), 16'(tbl[k].x_rd_addr));
      check($sformatf("t1[%0d] busy", k), 16'(busy), 16'(tbl[k].x_busy));
      check($sformatf("t1[%0d] done", k), 16'(done), 16'(tbl[k].x_done));
      if (tbl[k].chk_c_n_est)
        check($sformatf("t1[%0d] c_n_est", k), 16'(c_n_est), 16'(tbl[k].x_c_n_est));
      if (tbl[k].x_done) done_cyc = cyc;
      step();
    end
    start = 1'b0; gen_valid = 1'b0;
    check("t1_seq_len", 16'(done_cyc - c0 + 1), 16'd34);
    check("t1_done_count", 16'(done_cnt - d0), 16'd1);
    check("t1_write_count", 16'(wr_total - w0), 16'd16);

    // 2. Generator gaps.
    d0 = done_cnt; w0 = wr_total;
    pulse_start();
    fill(16'h3C96, 1'b1, -1, 16);
    read_seq(16'h3C96, -1, 0, 16, 1'b0);
    check("t2_write_count", 16'(wr_total - w0), 16'd16);
    check("t2_done_count", 16'(done_cnt - d0), 16'd1);

    // 3. Estimator backpressure at address 5 for 3 cycles.
    c0 = cyc;
    pulse_start();
    fill(16'h5A0F, 1'b0, -1, 16);
    read_seq(16'h5A0F, 5, 3, 16, 1'b0);
    check("t3_seq_len", 16'(done_cyc - c0 + 1), 16'd37);

    // 4. Abort mid-fill at wr_cnt=7, then refill from address 0.
    d0 = done_cnt;
    pulse_start();
    fill(16'hFFFF, 1'b0, -1, 7);
    abort = 1'b1; gen_valid = 1'b1; c_n = 1'b1;
    #1;
    check("t4_abort_wr_en", 16'(wr_en), 16'd1);
    check("t4_abort_wr_addr", 16'(wr_addr), 16'd7);
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_idle_busy", 16'(busy), 16'd0);
      check("t4_idle_gen_req", 16'(gen_req), 16'd0);
      check("t4_idle_wr_en", 16'(wr_en), 16'd0);
      step();
    end
    gen_valid = 1'b0;
    check("t4_no_done", 16'(done_cnt - d0), 16'd0);
    pulse_start();
    fill(16'h0F0F, 1'b0, -1, 16);
    read_seq(16'h0F0F, -1, 0, 16, 1'b0);

    // 4b. Abort coinciding with the final write: the write lands, READ is skipped.
    pulse_start();
    fill(16'h1234, 1'b0, -1, 15);
    abort = 1'b1; gen_valid = 1'b1;
    #1;
    check("t4b_last_wr_en", 16'(wr_en), 16'd1);
    step();
    abort = 1'b0; gen_valid = 1'b0;
    #1;
    check("t4b_no_read", 16'(est_valid), 16'd0);
    check("t4b_busy", 16'(busy), 16'd0);
    check("t4b_rd_addr", 16'(rd_addr_est), 16'd0);

    // 4c. Start and abort in the same IDLE cycle: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    #1;
    check("t4c_start_abort_busy", 16'(busy), 16'd0);
    step();

    // 5. Reset mid-read at rd_cnt=10.
    pulse_start();
    fill(16'hC3A5, 1'b0, -1, 16);
    read_seq(16'hC3A5, -1, 0, 10, 1'b0);
    rst = 1'b1; est_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_est_valid", 16'(est_valid), 16'd0);
    check("t5_rd_addr", 16'(rd_addr_est), 16'd0);
    check("t5_busy", 16'(busy), 16'd0);
    check("t5_done", 16'(done), 16'd0);
    step();

    // 6. Start pulses in FILL and in DONE are ignored.
    d0 = done_cnt; w0 = wr_total;
    pulse_start();
    fill(16'h9E37, 1'b0, 5, 16);
    read_seq(16'h9E37, -1, 0, 16, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      check("t6_no_restart_busy", 16'(busy), 16'd0);
      check("t6_no_restart_gen_req", 16'(gen_req), 16'd0);
    end
    check("t6_done_count", 16'(done_cnt - d0), 16'd1);
    check("t6_write_count", 16'(wr_total - w0), 16'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
